// File: rtl/ysyx_210544_axi_burst.sv
// ysyx_210544_axi_burst: AXI4 INCR burst master turning one cache-line request into an AR/R or AW/W/B burst.
module ysyx_210544_axi_burst (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_axi_io_valid,
   output logic         o_axi_io_ready,
   input  logic         i_axi_io_op,
   input  logic [63:0]  i_axi_io_addr,
   input  logic [511:0] i_axi_io_wdata,
   input  logic [1:0]   i_axi_io_size,
   input  logic [7:0]   i_axi_io_blks,
   output logic [511:0] o_axi_io_rdata,
   output logic         axi_ar_valid,
   input  logic         axi_ar_ready,
   output logic [63:0]  axi_ar_addr,
   output logic [7:0]   axi_ar_len,
   output logic [2:0]   axi_ar_size,
   output logic         axi_aw_valid,
   input  logic         axi_aw_ready,
   output logic [63:0]  axi_aw_addr,
   output logic [7:0]   axi_aw_len,
   output logic [2:0]   axi_aw_size,
   input  logic         axi_r_valid,
   output logic         axi_r_ready,
   input  logic [63:0]  axi_r_data,
   input  logic         axi_r_last,
   output logic         axi_w_valid,
   input  logic         axi_w_ready,
   output logic [63:0]  axi_w_data,
   output logic [7:0]   axi_w_strb,
   output logic         axi_w_last,
   input  logic         axi_b_valid,
   output logic         axi_b_ready
);
   typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_e;
   state_e       state_q;
   logic [2:0]   k_q;
   logic [63:0]  addr_q;
   logic [7:0]   blks_q;
   logic [1:0]   size_q;
   logic [511:0] wdata_q;
   logic [511:0] rdata_q;
   logic [7:0]   strb_q;
   logic [7:0]   strb_d;
   logic         hold_q;
   logic         last_beat;
   assign strb_d = (i_axi_io_size == 2'd3) ? 8'hFF
                 : ((8'd1 << (4'd1 << i_axi_io_size)) - 8'd1) << i_axi_io_addr[2:0];
   assign last_beat = k_q == blks_q[2:0];
   // hold_q blocks acceptance for one IDLE cycle so a request still held after ready is not re-run
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         addr_q  <= '0;
         blks_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         strb_q  <= '0;
         hold_q  <= 1'b0;
      end else
         case (state_q)
            IDLE: begin
               hold_q <= 1'b0;
               if (i_axi_io_valid && !hold_q) begin
                  addr_q  <= i_axi_io_addr;
                  blks_q  <= i_axi_io_blks;
                  size_q  <= i_axi_io_size;
                  wdata_q <= i_axi_io_wdata;
                  strb_q  <= strb_d;
                  k_q     <= '0;
                  state_q <= i_axi_io_op ? AW : AR;
               end
            end
            AR: if (axi_ar_ready) state_q <= R;
            R: if (axi_r_valid) begin
               rdata_q[{k_q, 6'd0} +: 64] <= axi_r_data;
               k_q <= k_q + 3'd1;
               if (axi_r_last || last_beat) state_q <= DONE;
            end
            AW: if (axi_aw_ready) state_q <= W;
            W: if (axi_w_ready) begin
               k_q <= k_q + 3'd1;
               if (last_beat) state_q <= B;
            end
            B: if (axi_b_valid) state_q <= DONE;
            DONE: begin
               hold_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
   assign o_axi_io_ready = state_q == DONE;
   assign o_axi_io_rdata = rdata_q;
   assign axi_ar_valid   = state_q == AR;
   assign axi_ar_addr    = addr_q;
   assign axi_ar_len     = blks_q;
   assign axi_ar_size    = {1'b0, size_q};
   assign axi_aw_valid   = state_q == AW;
   assign axi_aw_addr    = addr_q;
   assign axi_aw_len     = blks_q;
   assign axi_aw_size    = {1'b0, size_q};
   assign axi_r_ready    = state_q == R;
   assign axi_w_valid    = state_q == W;
   assign axi_w_data     = wdata_q[{k_q, 6'd0} +: 64];
   assign axi_w_strb     = strb_q;
   assign axi_w_last     = state_q == W && last_beat;
   assign axi_b_ready    = state_q == B;
endmodule

// File: doc/ysyx_210544_axi_burst.md
# ysyx_210544_axi_burst

AXI4 burst master sitting directly downstream of the cache AXI unit. It accepts one cache-line request at a time over the simple `axi_io` valid/ready interface (op, address, 512-bit write data, size, beat count), and runs it as one INCR burst on the AXI4 read channels (AR/R) or write channels (AW/W/B). It packs read beats into a 512-bit line, returns that line, and pulses ready once when the burst completes.

## Interface
Parameters:
- none. Beat width is fixed at 64 bit, at most 8 beats; ID, burst, cache and prot are tied off at top level (ID 0, INCR).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `i_axi_io_valid`  in  1  request valid; held until `o_axi_io_ready`
- `o_axi_io_ready`  out  1  one-cycle completion pulse
- `i_axi_io_op`  in  1  0 read, 1 write
- `i_axi_io_addr`  in  64  start byte address
- `i_axi_io_wdata`  in  512  write line; beat k = bits [64k+63:64k]
- `i_axi_io_size`  in  2  bytes per beat = 2^size
- `i_axi_io_blks`  in  8  beats−1 (0..7)
- `o_axi_io_rdata`  out  512  read line, same beat packing
- `axi_ar_valid` / `axi_aw_valid`  out  1  address valid
- `axi_ar_ready` / `axi_aw_ready`  in  1  address ready
- `axi_ar_addr` / `axi_aw_addr`  out  64  latched request address
- `axi_ar_len` / `axi_aw_len`  out  8  latched blks
- `axi_ar_size` / `axi_aw_size`  out  3  {1'b0, latched size}
- `axi_r_valid`  in  1  read beat valid
- `axi_r_ready`  out  1  read beat ready
- `axi_r_data`  in  64  read beat data
- `axi_r_last`  in  1  last read beat
- `axi_w_valid`  out  1  write beat valid
- `axi_w_ready`  in  1  write beat ready
- `axi_w_data`  out  64  write beat data
- `axi_w_strb`  out  8  write byte strobes
- `axi_w_last`  out  1  last write beat
- `axi_b_valid`  in  1  write response valid
- `axi_b_ready`  out  1  write response ready

## Operation
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE: when `i_axi_io_valid` is high, latch op, addr, size, blks and wdata, clear the beat counter `k` (3 bit), and go to AR (op=0) or AW (op=1).
- AR/AW: assert the channel's valid, with addr, len and size driven from latches. On handshake, go to R or W.
- R: `axi_r_ready` is high. On each beat handshake, write `axi_r_data` into `o_axi_io_rdata[64k+:64]` and increment `k`. Go to DONE when the handshake has `axi_r_last` set or `k==blks`, whichever comes first. Beats beyond blks never occur.
- W: `axi_w_valid` is high with `axi_w_data = wdata[64k+:64]` and `axi_w_last = (k==blks)`. Increment `k` on each handshake. After the last handshake, go to B.
- Strobe: size 3 gives 8'hFF. Otherwise it is ((1<<2^size)−1) << addr[2:0], truncated to 8 bits, and the same value is used for every beat.
- B: `axi_b_ready` is high. On handshake, go to DONE. bresp and rresp are ignored.
- DONE: `o_axi_io_ready`=1 for exactly one cycle, then IDLE.
- `o_axi_io_rdata` is updated only in R. It holds its value across DONE and IDLE until the next read overwrites it. Unwritten beats keep their old contents.
- Input changes after the IDLE latch do not affect an in-flight burst.

## Timing
- Reset (asynchronous, `rst`=0): state IDLE, k=0, `o_axi_io_rdata`=0. All valid, ready and last outputs are 0; addr, len, size, data and strb outputs are 0.
- All outputs are registered or decoded from state plus latches. There is no combinational path from AXI inputs to AXI outputs.
- With a zero-wait slave (ready/valid always high), taking acceptance edge E0:
  - 8-beat read: AR handshake at E1, beats at E2–E9, `o_axi_io_ready` high in the cycle after E9.
  - 8-beat write: AW at E1, W at E2–E9, B handshake at E10, ready high in the cycle after E10.
- Back-to-back: after DONE, at least one IDLE cycle elapses. This lets the upstream drop valid after its handshake, so a request is not re-accepted twice.
- Slave stalls (ready or valid low) hold the state, `k` and all outputs stable.
- Reset asserted mid-burst: the burst is abandoned immediately, all outputs return to reset values, and no ready pulse is issued.

## Test plan
- Read, addr 0x8000_0040, blks 7, size 3, zero-wait slave returning beats 0x11..11 to 0x88..88 → `ar_addr`=0x8000_0040, `ar_len`=7, `ar_size`=3; rdata[63:0]=0x1111…, rdata[511:448]=0x8888…; ready pulses once, 10 cycles after E0.
- Write, blks 7, wdata beat k = k+1, with `w_ready` toggling every cycle → 8 beats carry 1..8 in order, `w_last` only on beat 8, strb FF, ready once after the B handshake.
- Single-beat write, size 2, addr[2:0]=4 → `aw_len`=0, strb 8'hF0, `w_last` on the first beat.
- Read where the slave asserts `r_last` at beat 3 with blks=7 → DONE after 4 beats; rdata beats 4–7 keep their previous values.
- Reset pulled low during W beat 3 → all outputs 0 immediately; after release the next request starts cleanly from IDLE.
- Upstream valid held high one extra cycle after ready → no second burst issued.
